// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the boot loader state encoding.
// Controller code reuses the same state names for consistency.
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 1000;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/loader_watchdog.sv
// Inter-byte idle watchdog for the program loader: counts cycles without an
// accepted byte while enabled and pulses o_expire on the last allowed cycle.
module loader_watchdog #(
    parameter int TIMEOUT = cpu_pkg::TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_accept,
    output logic o_expire
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_timer;
    logic          w_expire;

    assign w_expire = i_en && !i_accept && (r_timer == TW'(TIMEOUT - 1));
    assign o_expire = w_expire;

    // Clearing on expiry keeps the counter at zero for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!i_en || i_accept || w_expire) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: receives a length/payload/checksum frame, writes the payload
// into memory from address 0 and releases the CPU only after a good checksum.
module program_loader #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int DEPTH   = cpu_pkg::DEPTH,
    parameter int TIMEOUT = cpu_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   bytes_loaded
);

    import cpu_pkg::*;

    localparam int unsigned DEPTH_U = DEPTH;

    loader_state_t r_state;
    loader_state_t w_next;

    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_rst;
    logic              r_load_done;
    logic              r_load_err;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_sum;

    logic              w_accept;
    logic              w_active;
    logic              w_can_start;
    logic              w_expire;
    logic [DATA_W-1:0] w_sum_next;

    assign w_accept    = in_valid && r_in_ready;
    assign w_active    = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
    assign w_can_start = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_sum_next  = r_sum + in_data;

    loader_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_active),
        .i_accept (w_accept),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = LEN;
            end
            LEN: begin
                if (w_expire) begin
                    w_next = ERR;
                end else if (w_accept) begin
                    if ((in_data == '0) || (32'(in_data) > DEPTH_U)) w_next = ERR;
                    else                                            w_next = DATA;
                end
            end
            DATA: begin
                if (w_expire)                                   w_next = ERR;
                else if (w_accept && (r_cnt + 1'b1 == r_len))   w_next = CSUM;
            end
            CSUM: begin
                if (w_expire) begin
                    w_next = ERR;
                end else if (w_accept) begin
                    w_next = (w_sum_next == '0) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (start) w_next = LEN;
            end
            default: w_next = IDLE;
        endcase
    end

    // Status outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_sum       <= '0;
        end else begin
            r_mem_we    <= 1'b0;
            r_in_ready  <= (w_next == LEN) || (w_next == DATA) || (w_next == CSUM);
            r_cpu_rst   <= (w_next != DONE);
            r_load_done <= (w_next == DONE);
            r_load_err  <= (w_next == ERR);
            if (w_can_start) begin
                r_sum <= '0;
                r_cnt <= '0;
            end
            if ((r_state == LEN) && w_accept) begin
                r_len <= in_data[ADDR_W:0];
            end
            if ((r_state == DATA) && w_accept) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_cnt[ADDR_W-1:0];
                r_mem_wdata <= in_data;
                r_sum       <= w_sum_next;
                r_cnt       <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_rst      = r_cpu_rst;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;
    assign bytes_loaded = r_cnt;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; memory writes are checked against a
// scoreboard of expected (address, data) pairs filled as payload bytes are sent.
module tb_program_loader;

    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst;
    logic       load_done;
    logic       load_err;
    logic [5:0] bytes_loaded;

    int n_total = 0;
    int n_pass  = 0;
    int wr_cnt  = 0;

    logic [12:0] sb_q[$];
    logic [7:0]  pay_q[$];

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            logic [12:0] e;
            wr_cnt++;
            chk("we_with_cpu_rst", cpu_rst, 1);
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_wdata}, 13'h1fff);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", mem_addr, e[12:8]);
                chk("wr_data", mem_wdata, e[7:0]);
                $display("write addr=%02h data=%02h", mem_addr, mem_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit push, input logic [4:0] addr);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready", in_ready, 1);
        if (push) sb_q.push_back({addr, b});
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_flag();
        int n;
        n = 0;
        while (!(load_done || load_err) && n < 8) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [7:0] good_csum();
        logic [7:0] s;
        s = 8'h00;
        foreach (pay_q[i]) s = s + pay_q[i];
        return 8'h00 - s;
    endfunction

    task automatic send_frame(input logic [7:0] len, input logic [7:0] csum, input bit gap);
        send(len, 1'b0, 5'd0);
        foreach (pay_q[i]) begin
            send(pay_q[i], 1'b1, 5'(i));
            if (gap) begin
                in_valid = 1'b0;
                tick();
            end
        end
        send(csum, 1'b0, 5'd0);
        in_valid = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [5:0] nbytes);
        wait_flag();
        chk({tag, "_done"}, load_done, 1);
        chk({tag, "_err"}, load_err, 0);
        chk({tag, "_cpu_rst"}, cpu_rst, 0);
        chk({tag, "_bytes"}, bytes_loaded, nbytes);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
        $display("%s: done=%0b err=%0b bytes=%0d", tag, load_done, load_err, bytes_loaded);
    endtask

    task automatic check_err(input string tag, input logic [5:0] nbytes);
        wait_flag();
        chk({tag, "_err"}, load_err, 1);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_bytes"}, bytes_loaded, nbytes);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
        $display("%s: done=%0b err=%0b bytes=%0d", tag, load_done, load_err, bytes_loaded);
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_bytes", bytes_loaded, 0);
        rst = 1'b0;
        tick();

        // 1: good three-byte frame streamed back to back
        pulse_start();
        chk("t1_ready_in_len", in_ready, 1);
        pay_q = '{8'hA0, 8'h3F, 8'h01};
        base = wr_cnt;
        send_frame(8'h03, 8'h20, 1'b0);
        check_done("t1", 6'd3);
        chk("t1_writes", wr_cnt - base, 3);
        chk("t1_ready_done", in_ready, 0);

        // 2: same payload, bad checksum
        pulse_start();
        chk("t2_cpu_rst_on_start", cpu_rst, 1);
        chk("t2_done_cleared", load_done, 0);
        base = wr_cnt;
        send_frame(8'h03, 8'h21, 1'b0);
        check_err("t2", 6'd3);
        chk("t2_writes", wr_cnt - base, 3);

        // 3: illegal lengths 0 and DEPTH+1
        pulse_start();
        chk("t3_err_cleared", load_err, 0);
        base = wr_cnt;
        send(8'h00, 1'b0, 5'd0);
        in_valid = 1'b0;
        check_err("t3_len0", 6'd0);
        pulse_start();
        send(8'h21, 1'b0, 5'd0);
        in_valid = 1'b0;
        check_err("t3_len33", 6'd0);
        chk("t3_writes", wr_cnt - base, 0);

        // 4: full-depth frame
        pay_q.delete();
        for (int i = 0; i < 32; i++) pay_q.push_back(8'(i));
        pulse_start();
        base = wr_cnt;
        send_frame(8'h20, good_csum(), 1'b0);
        check_done("t4", 6'd32);
        chk("t4_writes", wr_cnt - base, 32);

        // 5: stall inside DATA until the watchdog fires
        pulse_start();
        send(8'h02, 1'b0, 5'd0);
        send(8'h11, 1'b1, 5'd0);
        in_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT - 1) chk("t5_err_early", load_err, 0);
            if (k == TIMEOUT)     chk("t5_err_on_time", load_err, 1);
        end
        chk("t5_ready", in_ready, 0);
        chk("t5_cpu_rst", cpu_rst, 1);
        chk("t5_bytes", bytes_loaded, 1);
        chk("t5_sb_empty", sb_q.size(), 0);
        $display("t5: err=%0b after %0d idle cycles", load_err, TIMEOUT);

        // 6: asynchronous reset in the middle of DATA
        pulse_start();
        send(8'h05, 1'b0, 5'd0);
        send(8'h01, 1'b1, 5'd0);
        send(8'h02, 1'b0, 5'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_mem_we", mem_we, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_mem_wdata", mem_wdata, 0);
        chk("t6_bytes", bytes_loaded, 0);
        chk("t6_ready", in_ready, 0);
        chk("t6_cpu_rst", cpu_rst, 1);
        $display("t6: async reset, we=%0b bytes=%0d", mem_we, bytes_loaded);
        tick();
        rst = 1'b0;
        tick();
        pay_q = '{8'h55};
        pulse_start();
        send_frame(8'h01, 8'hAB, 1'b0);
        check_done("t6", 6'd1);

        // 7: in_valid alternating during the payload
        pay_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        pulse_start();
        base = wr_cnt;
        send_frame(8'h04, good_csum(), 1'b1);
        check_done("t7", 6'd4);
        chk("t7_writes", wr_cnt - base, 4);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
